// File: rtl/mmu_pkg.sv
// mmu_pkg: shared constants, types and lane helpers for the mmu block.
// Memory map: IMEM at 0x0000_0000, DMEM at 0x1000_0000, IO at 0x8000_0000.
package mmu_pkg;

   // Region decode on addr[31:28]
   localparam int         REGION_W     = 4;
   localparam logic [3:0] REGION_IMEM  = 4'h0;
   localparam logic [3:0] REGION_DMEM  = 4'h1;
   localparam logic [3:0] REGION_IO    = 4'h8;

   // IO word index on addr[3:2]
   localparam logic [1:0] IO_LED       = 2'd0;
   localparam logic [1:0] IO_CNT_LO    = 2'd1;
   localparam logic [1:0] IO_CNT_HI    = 2'd2;

   // addi x0,x0,0 -- harmless first fetch while the core leaves reset
   localparam logic [31:0] NOP_INSN    = 32'h0000_0013;

   // Source of the word held in the load pipeline
   typedef enum logic [1:0] {
      SRC_NONE = 2'd0,
      SRC_IMEM = 2'd1,
      SRC_DMEM = 2'd2,
      SRC_IO   = 2'd3
   } ld_src_e;

   // Source of the fetch output
   typedef enum logic [1:0] {
      FSEL_NOP  = 2'd0,
      FSEL_MEM  = 2'd1,
      FSEL_ZERO = 2'd2
   } fetch_sel_e;

   // Spread store data over the lanes so any enabled lane sees the right bytes
   function automatic logic [31:0] store_replicate(input logic [31:0] di, input logic [3:0] be);
      logic [31:0] r;
      case (be)
         4'b0001, 4'b0010, 4'b0100, 4'b1000: r = {4{di[7:0]}};
         4'b0011, 4'b1100:                   r = {2{di[15:0]}};
         default:                            r = di;
      endcase
      return r;
   endfunction

   // Right-justify the selected lanes and extend according to access width
   function automatic logic [31:0] load_align(input logic [31:0] word, input logic [1:0] off,
                                              input logic [3:0] be, input logic sgn);
      logic [31:0] sh;
      logic [31:0] r;
      sh = word >> {off, 3'b000};
      case (be)
         4'b0001, 4'b0010, 4'b0100, 4'b1000: r = {{24{sgn & sh[7]}}, sh[7:0]};
         4'b0011, 4'b1100:                   r = {{16{sgn & sh[15]}}, sh[15:0]};
         4'b1111:                            r = word;
         default:                            r = 32'h0000_0000;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/mmu_bram.sv
// mmu_bram: single-clock synchronous RAM, one byte-enabled write port and
// NRD registered read ports. Contents are never reset.
module mmu_bram #(
   parameter int WORDS     = 1024,
   parameter int AW        = 10,
   parameter int NRD       = 1,
   parameter     INIT_FILE = ""
) (
   input  logic                    clk,
   input  logic                    we,
   input  logic [3:0]              be,
   input  logic [AW-1:0]           waddr,
   input  logic [31:0]             wdata,
   input  logic [NRD-1:0][AW-1:0]  raddr,
   output logic [NRD-1:0][31:0]    rdata
);

   logic [31:0] mem [0:WORDS-1];

   // Byte-lane write at the clock edge ending the store cycle
   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
               mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
         end
      end
   end

   // Registered read on every port, one cycle latency
   always_ff @(posedge clk) begin
      for (int p = 0; p < NRD; p++) begin
         rdata[p] <= mem[raddr[p]];
      end
   end

endmodule

// File: rtl/mmu.sv
// mmu: fetch and load/store front end for the two-stage RV32I core.
// One-cycle latency on both ports. Optional 64-bit cycle counter with an
// atomic lo-then-hi shadow is built when MMU_CYCLE_COUNTER_EN is defined;
// otherwise CNT_LO/CNT_HI read as zero.
module mmu #(
   parameter int IMEM_WORDS = 1024,
   parameter int DMEM_WORDS = 1024,
   parameter     IMEM_INIT  = "imem.hex"
) (
   input  logic        clk,
   input  logic        resetb,
   input  logic [31:0] im_addr,
   output logic [31:0] im_do,
   input  logic [31:0] dm_addr,
   input  logic [31:0] dm_di,
   input  logic [3:0]  dm_be,
   input  logic        dm_we,
   input  logic        dm_is_signed,
   output logic [31:0] dm_do,
   output logic [7:0]  led
);
   import mmu_pkg::*;

   localparam int IAW = $clog2(IMEM_WORDS);
   localparam int DAW = $clog2(DMEM_WORDS);

   // Address decode
   logic [REGION_W-1:0] region_s;
   logic                fetch_ok_s;
   logic                imem_hit_s, dmem_hit_s, io_hit_s;
   logic [1:0]          io_idx_s;
   logic                is_load_s, is_store_s;
   logic [31:0]         wdata_s;
   logic                dmem_we_s;
   logic [31:0]         cnt_lo_s, cnt_hi_s;
   logic                unused_s;

   assign region_s   = dm_addr[31:28];
   assign fetch_ok_s = ({2'b00, im_addr[31:2]} < 32'(IMEM_WORDS));
   assign imem_hit_s = (region_s == REGION_IMEM) && ({6'd0, dm_addr[27:2]} < 32'(IMEM_WORDS));
   assign dmem_hit_s = (region_s == REGION_DMEM) && ({6'd0, dm_addr[27:2]} < 32'(DMEM_WORDS));
   assign io_hit_s   = (region_s == REGION_IO) && (dm_addr[27:4] == 24'd0);
   assign io_idx_s   = dm_addr[3:2];
   assign is_load_s  = (dm_be != 4'b0000) && !dm_we;
   assign is_store_s = (dm_be != 4'b0000) && dm_we;
   assign wdata_s    = store_replicate(dm_di, dm_be);
   assign dmem_we_s  = is_store_s && dmem_hit_s;
   assign unused_s   = ^im_addr[1:0];

   // Memories
   logic [1:0][IAW-1:0] imem_raddr_s;
   logic [1:0][31:0]    imem_rdata_s;
   logic [0:0][DAW-1:0] dmem_raddr_s;
   logic [0:0][31:0]    dmem_rdata_s;

   assign imem_raddr_s[0] = im_addr[IAW+1:2];
   assign imem_raddr_s[1] = dm_addr[IAW+1:2];
   assign dmem_raddr_s[0] = dm_addr[DAW+1:2];

   mmu_bram #(.WORDS(IMEM_WORDS), .AW(IAW), .NRD(2), .INIT_FILE(IMEM_INIT)) u_imem (
      .clk   (clk),
      .we    (1'b0),
      .be    (4'b0000),
      .waddr ({IAW{1'b0}}),
      .wdata (32'h0000_0000),
      .raddr (imem_raddr_s),
      .rdata (imem_rdata_s)
   );

   mmu_bram #(.WORDS(DMEM_WORDS), .AW(DAW), .NRD(1), .INIT_FILE("")) u_dmem (
      .clk   (clk),
      .we    (dmem_we_s),
      .be    (dm_be),
      .waddr (dm_addr[DAW+1:2]),
      .wdata (wdata_s),
      .raddr (dmem_raddr_s),
      .rdata (dmem_rdata_s)
   );

   // Cycle counter and its high-word shadow
`ifdef MMU_CYCLE_COUNTER_EN
   logic [63:0] cnt_q, cnt_d;
   logic [31:0] shadow_q, shadow_d;

   // Free-running count; CNT_LO loads snapshot the high word for the next read
   always_comb begin
      cnt_d    = cnt_q + 64'd1;
      shadow_d = shadow_q;
      if (is_load_s && io_hit_s && (io_idx_s == IO_CNT_LO)) begin
         shadow_d = cnt_q[63:32];
      end else begin
         shadow_d = shadow_q;
      end
   end

   // Counter state flops
   always_ff @(posedge clk or posedge resetb) begin
      if (resetb) begin
         cnt_q    <= 64'd0;
         shadow_q <= 32'd0;
      end else begin
         cnt_q    <= cnt_d;
         shadow_q <= shadow_d;
      end
   end

   assign cnt_lo_s = cnt_q[31:0];
   assign cnt_hi_s = shadow_q;
`else
   assign cnt_lo_s = 32'h0000_0000;
   assign cnt_hi_s = 32'h0000_0000;
`endif

   // Load pipeline, fetch select and LED state
   fetch_sel_e  fsel_q, fsel_d;
   ld_src_e     ld_src_q, ld_src_d;
   logic [1:0]  ld_off_q, ld_off_d;
   logic [3:0]  ld_be_q, ld_be_d;
   logic        ld_signed_q, ld_signed_d;
   logic [31:0] ld_io_q, ld_io_d;
   logic [7:0]  led_q, led_d;

   // Next-state for fetch select, load capture and LED writes
   always_comb begin
      fsel_d      = fetch_ok_s ? FSEL_MEM : FSEL_ZERO;
      ld_src_d    = SRC_NONE;
      ld_off_d    = 2'b00;
      ld_be_d     = 4'b0000;
      ld_signed_d = 1'b0;
      ld_io_d     = 32'h0000_0000;
      led_d       = led_q;
      if (is_load_s) begin
         ld_off_d    = dm_addr[1:0];
         ld_be_d     = dm_be;
         ld_signed_d = dm_is_signed;
         if (imem_hit_s) begin
            ld_src_d = SRC_IMEM;
         end else if (dmem_hit_s) begin
            ld_src_d = SRC_DMEM;
         end else if (io_hit_s) begin
            ld_src_d = SRC_IO;
            case (io_idx_s)
               IO_LED:    ld_io_d = {24'd0, led_q};
               IO_CNT_LO: ld_io_d = cnt_lo_s;
               IO_CNT_HI: ld_io_d = cnt_hi_s;
               default:   ld_io_d = 32'h0000_0000;
            endcase
         end else begin
            ld_src_d = SRC_NONE;
         end
      end else begin
         ld_src_d = SRC_NONE;
      end
      if (is_store_s && io_hit_s && (io_idx_s == IO_LED) && dm_be[0]) begin
         led_d = wdata_s[7:0];
      end else begin
         led_d = led_q;
      end
   end

   // Pipeline and LED flops
   always_ff @(posedge clk or posedge resetb) begin
      if (resetb) begin
         fsel_q      <= FSEL_NOP;
         ld_src_q    <= SRC_NONE;
         ld_off_q    <= 2'b00;
         ld_be_q     <= 4'b0000;
         ld_signed_q <= 1'b0;
         ld_io_q     <= 32'h0000_0000;
         led_q       <= 8'h00;
      end else begin
         fsel_q      <= fsel_d;
         ld_src_q    <= ld_src_d;
         ld_off_q    <= ld_off_d;
         ld_be_q     <= ld_be_d;
         ld_signed_q <= ld_signed_d;
         ld_io_q     <= ld_io_d;
         led_q       <= led_d;
      end
   end

   // Output selection from the registered state and RAM read registers
   always_comb begin
      logic [31:0] word_s;
      case (fsel_q)
         FSEL_NOP: im_do = NOP_INSN;
         FSEL_MEM: im_do = imem_rdata_s[0];
         default:  im_do = 32'h0000_0000;
      endcase
      case (ld_src_q)
         SRC_IMEM: word_s = imem_rdata_s[1];
         SRC_DMEM: word_s = dmem_rdata_s[0];
         SRC_IO:   word_s = ld_io_q;
         default:  word_s = 32'h0000_0000;
      endcase
      if (ld_src_q == SRC_NONE) begin
         dm_do = 32'h0000_0000;
      end else begin
         dm_do = load_align(word_s, ld_off_q, ld_be_q, ld_signed_q);
      end
   end

   assign led = led_q;

endmodule

// File: tb/tb_mmu.sv
// tb_mmu: directed-vector bench for mmu with hand-computed expectations.
module tb_mmu;

   logic        clk = 1'b0;
   logic        resetb;
   logic [31:0] im_addr, im_do;
   logic [31:0] dm_addr, dm_di, dm_do;
   logic [3:0]  dm_be;
   logic        dm_we, dm_is_signed;
   logic [7:0]  led;

   int n_total = 0;
   int n_bad   = 0;

   mmu #(.IMEM_WORDS(1024), .DMEM_WORDS(1024), .IMEM_INIT("")) dut (
      .clk          (clk),
      .resetb       (resetb),
      .im_addr      (im_addr),
      .im_do        (im_do),
      .dm_addr      (dm_addr),
      .dm_di        (dm_di),
      .dm_be        (dm_be),
      .dm_we        (dm_we),
      .dm_is_signed (dm_is_signed),
      .dm_do        (dm_do),
      .led          (led)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      dm_addr = a; dm_di = d; dm_be = be; dm_we = 1'b1;
      cyc();
      dm_be = 4'b0000; dm_we = 1'b0;
   endtask

   task automatic ld_chk(input string tag, input logic [31:0] a, input logic [3:0] be,
                         input logic sgn, input logic [31:0] exp);
      dm_addr = a; dm_be = be; dm_we = 1'b0; dm_is_signed = sgn;
      cyc();
      chk(tag, dm_do, exp);
      dm_be = 4'b0000; dm_is_signed = 1'b0;
   endtask

   initial begin
      resetb = 1'b1;
      im_addr = 32'h0; dm_addr = 32'h0; dm_di = 32'h0;
      dm_be = 4'b0000; dm_we = 1'b0; dm_is_signed = 1'b0;
      dut.u_imem.mem[0]  = 32'h0050_0093;
      dut.u_imem.mem[16] = 32'hCAFE_F00D;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_im_do", im_do, 32'h0000_0013);
      chk("rst_dm_do", dm_do, 32'h0000_0000);
      chk("rst_led", {24'd0, led}, 32'h0000_0000);

      resetb = 1'b0;
      cyc();
      chk("fetch0", im_do, 32'h0050_0093);
      im_addr = 32'h0000_0043;
      cyc();
      chk("fetch_lowbits", im_do, 32'hCAFE_F00D);
      im_addr = 32'h0000_1000;
      cyc();
      chk("fetch_oob", im_do, 32'h0000_0000);

      // Word store then narrow loads
      st(32'h1000_0010, 32'hDEAD_BEEF, 4'b1111);
      ld_chk("lb_s",  32'h1000_0013, 4'b1000, 1'b1, 32'hFFFF_FFDE);
      ld_chk("lbu",   32'h1000_0013, 4'b1000, 1'b0, 32'h0000_00DE);
      ld_chk("lh_s",  32'h1000_0010, 4'b0011, 1'b1, 32'hFFFF_BEEF);
      ld_chk("lhu_hi",32'h1000_0012, 4'b1100, 1'b0, 32'h0000_DEAD);
      ld_chk("lw",    32'h1000_0010, 4'b1111, 1'b0, 32'hDEAD_BEEF);
      cyc();
      chk("idle_dm_do", dm_do, 32'h0000_0000);

      // Byte store into a zero word
      st(32'h1000_0020, 32'h0000_0000, 4'b1111);
      st(32'h1000_0021, 32'h0000_005A, 4'b0010);
      ld_chk("sb_lw",  32'h1000_0020, 4'b1111, 1'b0, 32'h0000_5A00);
      ld_chk("sb_lbu", 32'h1000_0021, 4'b0010, 1'b1, 32'h0000_005A);

      // Upper half store, signed readback
      st(32'h1000_0030, 32'h0000_0000, 4'b1111);
      st(32'h1000_0032, 32'h0000_8001, 4'b1100);
      ld_chk("sh_lw", 32'h1000_0030, 4'b1111, 1'b0, 32'h8001_0000);
      ld_chk("sh_lh", 32'h1000_0032, 4'b1100, 1'b1, 32'hFFFF_8001);

      // LED register
      st(32'h8000_0000, 32'h1234_5678, 4'b1111);
      chk("led_sw", {24'd0, led}, 32'h0000_0078);
      st(32'h8000_0001, 32'h0000_00AA, 4'b0010);
      chk("led_nobe0", {24'd0, led}, 32'h0000_0078);
      ld_chk("led_lw", 32'h8000_0000, 4'b1111, 1'b0, 32'h0000_0078);

      // IMEM is read-only from the data port
      ld_chk("imem_rd0", 32'h0000_0000, 4'b1111, 1'b0, 32'h0050_0093);
      st(32'h0000_0040, 32'h1111_1111, 4'b1111);
      ld_chk("imem_ro", 32'h0000_0040, 4'b1111, 1'b0, 32'hCAFE_F00D);

      // Unmapped / out-of-range
      ld_chk("unmapped", 32'h4000_0000, 4'b1111, 1'b0, 32'h0000_0000);
      ld_chk("dmem_oob", 32'h1000_1000, 4'b1111, 1'b0, 32'h0000_0000);

`ifdef MMU_CYCLE_COUNTER_EN
      force dut.cnt_q = 64'h0000_0000_FFFF_FFFF;
      release dut.cnt_q;
      ld_chk("cnt_lo", 32'h8000_0004, 4'b1111, 1'b0, 32'hFFFF_FFFF);
      ld_chk("cnt_hi", 32'h8000_0008, 4'b1111, 1'b0, 32'h0000_0000);
`else
      ld_chk("cnt_lo_off", 32'h8000_0004, 4'b1111, 1'b0, 32'h0000_0000);
      ld_chk("cnt_hi_off", 32'h8000_0008, 4'b1111, 1'b0, 32'h0000_0000);
`endif

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
